gmii_tx_arb: RTL and testbench
==============================

# gmii_tx_arb

Two-port transmit arbiter for the GMII Tx path. Two packet sources share one PHY transmit interface: for example, the UDP/ARP reply engine and a future streaming waveform source. The block grants the PHY to one source at a time, round-robin. It forwards that source's byte stream with one register stage and enforces the inter-packet gap. Watchdogs catch a source that never starts or never ends a packet. It sits between the Ethernet core's Tx byte streams and the GMII_TXD/TX_EN/TX_ER pins, clocked by the Tx clock that also drives the GTX_CLK ODDR.

## Interface
- `ipg`, 12: idle cycles forced on `gmii_tx_en` after each packet (min 1).
- `start_timeout`, 16: cycles a granted source may take to raise `en` before the grant is withdrawn.
- `max_len_dw`, 14: width of the packet length counter. The maximum packet length is 2^max_len_dw − 1 bytes (16383).

Ports:
- `clk` in 1: GMII Tx clock (125 MHz).
- `rst_n` in 1: asynchronous assert, active low; deassertion is synchronized externally.
- `req` in 2: per-source request. Held high until the source's first `en`.
- `grant` out 2: one-hot grant, or 0.
- `src_d0`, `src_d1` in 8 each: source data.
- `src_en` in 2: per-source byte valid. Must be contiguous for the packet.
- `src_er` in 2: per-source error flag.
- `gmii_txd` out 8, `gmii_tx_en` out 1, `gmii_tx_er` out 1: PHY outputs, all registered.
- `busy` out 1: high in every state except IDLE.
- `pkt_count` out 8: packets completed normally. Wraps.
- `abort_count` out 8: start timeouts plus truncations. Wraps.

## Operation
- States: IDLE, WAIT, PASS, DRAIN, GAP.
- IDLE: with `req`==0, stay in IDLE.
  - Exactly one `req` set: grant that source.
  - Both set: grant the source that was not granted last (`last` pointer, reset value 1, so source 0 wins first).
  - Update `last`, go to WAIT.
- WAIT: the timeout counter counts cycles while the granted `src_en` is low.
  - `src_en` high: forward the byte, clear the length counter to 1, go to PASS.
  - Counter reaches `start_timeout`: clear `grant`, increment `abort_count`, go to GAP.
- PASS: forward the granted source's d/en/er each cycle; the length counter increments per byte.
  - `src_en` low: clear `grant`, increment `pkt_count`, load the gap counter with `ipg`, go to GAP.
  - Length reaches 2^max_len_dw − 1 with `src_en` still high: output that byte with `gmii_tx_er`=1, then force `gmii_tx_en`=0. Clear `grant`, increment `abort_count`, go to DRAIN.
- DRAIN: outputs idle. Wait for the granted `src_en` to go low, then load the gap counter and go to GAP.
- GAP: outputs idle for `ipg` cycles, then go to IDLE.
- The non-granted source's `src_en`, `src_er` and data are ignored in all states. Its `req` stays pending and wins next, so no source can starve the other.
- Idle output value: `gmii_txd`=0, `gmii_tx_en`=0, `gmii_tx_er`=0.
- Reset values: state IDLE, `grant`=0, all GMII outputs 0, `busy`=0, both counters 0, `last`=1.
- Reset in mid-packet truncates the frame immediately. Outputs go to 0 asynchronously. There is no recovery of the partial frame.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N gives `grant` high after edge N.
- A source may present its first byte in the same cycle it sees `grant`.
- Data latency: a source byte sampled at edge M appears on `gmii_txd` after edge M, one cycle later. The preamble/SFD must be supplied by the source.
- End of packet: `src_en` low at edge K clears `grant` after K; `gmii_tx_en` goes low after K.
- Gap: `gmii_tx_en` stays low for at least `ipg`+1 cycles between frames (GAP plus the IDLE arbitration cycle).
- If a source drops `req` while in WAIT, the timeout still governs; the grant is not withdrawn early.
- `busy` is registered together with the state.

## Test plan
- Single source: source 0 sends a 64-byte frame 0x00..0x3F with `req` held. Expect `grant`=01 one cycle later and `gmii_txd` reproducing 0x00..0x3F with one cycle of delay. Expect `gmii_tx_en` high exactly 64 cycles, `pkt_count`=1, `abort_count`=0.
- Contention: both `req` raised in the same cycle after reset, each source sending 60-byte frames back to back. Expect grants in the order 0,1,0,1. Expect ≥13 idle cycles between frames on `gmii_tx_en`.
- Start timeout: source 1 requests and never asserts `en`. Expect `grant`=10 for 16 cycles then 0, `abort_count`=1, no `gmii_tx_en` activity, and a return to IDLE after 12 gap cycles.
- Truncation: with `max_len_dw`=6, source 0 holds `en` for 100 bytes. Expect 63 bytes out, the 63rd with `gmii_tx_er`=1. Expect `gmii_tx_en` low from the next cycle, DRAIN until `en` falls, and `abort_count`=1.
- Async reset: assert `rst_n`=0 at byte 20 of a frame. Expect all outputs 0 immediately, with no clock edge needed. After release, a fresh request is served normally.
- Ignore non-granted: while source 0 is in PASS, source 1 toggles `en` with data 0xFF. Expect no 0xFF on `gmii_txd`.

Source files
------------

// File: rtl/gmii_tx_arb_if.sv
// -----------------------------------------------------------------------------
// gmii_tx_arb_if
// Source-side bundle of the two-port GMII transmit arbiter.
//   req    : per-source request, held until that source's first byte
//   grant  : one-hot grant from the arbiter (or 0)
//   src_d0 : data byte of source 0
//   src_d1 : data byte of source 1
//   src_en : per-source byte valid, contiguous for one packet
//   src_er : per-source error flag
// The packet sources use the master modport, the arbiter uses slave.
// -----------------------------------------------------------------------------
interface gmii_tx_arb_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic [7:0] src_d0;
  logic [7:0] src_d1;
  logic [1:0] src_en;
  logic [1:0] src_er;

  modport master (
    output req,
    output src_d0,
    output src_d1,
    output src_en,
    output src_er,
    input  grant
  );

  modport slave (
    input  req,
    input  src_d0,
    input  src_d1,
    input  src_en,
    input  src_er,
    output grant
  );
endinterface

// File: rtl/gmii_tx_arb.sv
// -----------------------------------------------------------------------------
// gmii_tx_arb
// Round-robin arbiter that shares one GMII transmit interface between two
// byte-stream packet sources. The granted stream is forwarded with one
// register stage, an inter-packet gap is enforced, and two watchdogs handle
// a source that never starts (start timeout) or never ends (length limit).
//
// Parameters:
//   IPG           : idle cycles forced after each packet (>= 1)
//   START_TIMEOUT : cycles a granted source may take to raise its en (>= 1)
//   MAX_LEN_DW    : length counter width, longest packet 2^MAX_LEN_DW-1 (>= 2)
// Ports:
//   clk         : GMII Tx clock
//   rst_n       : asynchronous active-low reset
//   src         : source bundle (req/grant/data/en/er), slave side
//   gmii_txd    : registered PHY data
//   gmii_tx_en  : registered PHY enable
//   gmii_tx_er  : registered PHY error
//   busy        : high in every state except IDLE
//   pkt_count   : packets completed normally (wraps)
//   abort_count : start timeouts plus truncations (wraps)
// -----------------------------------------------------------------------------
module gmii_tx_arb #(
  parameter int IPG           = 12,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_LEN_DW    = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  gmii_tx_arb_if.slave        src,
  output logic [7:0]          gmii_txd,
  output logic                gmii_tx_en,
  output logic                gmii_tx_er,
  output logic                busy,
  output logic [7:0]          pkt_count,
  output logic [7:0]          abort_count
);

  localparam int GAP_W = $clog2(IPG + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);

  // A byte accepted while the counter holds LEN_LAST is the final legal byte.
  localparam logic [MAX_LEN_DW-1:0] LEN_LAST = {{(MAX_LEN_DW-1){1'b1}}, 1'b0};
  localparam logic [MAX_LEN_DW-1:0] LEN_ONE  = {{(MAX_LEN_DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PASS,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [MAX_LEN_DW-1:0] len_cnt_q, len_cnt_d;
  logic [7:0]            txd_q, txd_d;
  logic                  tx_en_q, tx_en_d;
  logic                  tx_er_q, tx_er_d;
  logic                  busy_q, busy_d;
  logic [7:0]            pkt_cnt_q, pkt_cnt_d;
  logic [7:0]            abort_cnt_q, abort_cnt_d;

  logic       pick;
  logic [7:0] sel_data;
  logic       sel_en;
  logic       sel_er;

  // sel_q keeps pointing at the granted source after grant is dropped so
  // that DRAIN can still watch its en.
  assign sel_data = sel_q ? src.src_d1 : src.src_d0;
  assign sel_en   = src.src_en[sel_q];
  assign sel_er   = src.src_er[sel_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    len_cnt_d   = len_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    abort_cnt_d = abort_cnt_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    // With both requests pending, the source not served last wins.
    pick        = ~last_q;

    case (state_q)
      S_IDLE: begin
        if (src.req != 2'b00) begin
          if (src.req != 2'b11) begin
            pick = src.req[1];
          end
          sel_d    = pick;
          last_d   = pick;
          grant_d  = pick ? 2'b10 : 2'b01;
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (sel_en) begin
          txd_d     = sel_data;
          tx_en_d   = 1'b1;
          tx_er_d   = sel_er;
          len_cnt_d = LEN_ONE;
          state_d   = S_PASS;
        end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
          grant_d     = 2'b00;
          abort_cnt_d = abort_cnt_q + 8'd1;
          gap_cnt_d   = GAP_W'(IPG);
          state_d     = S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_PASS: begin
        if (sel_en) begin
          txd_d     = sel_data;
          tx_en_d   = 1'b1;
          tx_er_d   = sel_er;
          len_cnt_d = len_cnt_q + LEN_ONE;
          // Over-length frame: mark the last byte bad and stop forwarding.
          if (len_cnt_q == LEN_LAST) begin
            tx_er_d     = 1'b1;
            grant_d     = 2'b00;
            abort_cnt_d = abort_cnt_q + 8'd1;
            state_d     = S_DRAIN;
          end
        end else begin
          grant_d   = 2'b00;
          pkt_cnt_d = pkt_cnt_q + 8'd1;
          gap_cnt_d = GAP_W'(IPG);
          state_d   = S_GAP;
        end
      end

      S_DRAIN: begin
        if (!sel_en) begin
          gap_cnt_d = GAP_W'(IPG);
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      len_cnt_q   <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      busy_q      <= 1'b0;
      pkt_cnt_q   <= 8'h00;
      abort_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      len_cnt_q   <= len_cnt_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      busy_q      <= busy_d;
      pkt_cnt_q   <= pkt_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign src.grant   = grant_q;
  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = tx_en_q;
  assign gmii_tx_er  = tx_er_q;
  assign busy        = busy_q;
  assign pkt_count   = pkt_cnt_q;
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_gmii_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_gmii_tx_arb
// Directed bench for gmii_tx_arb. One instance with default parameters
// carries the single-source, timeout, reset and contention sequences; a
// second instance with a 6-bit length counter carries the truncation case.
// -----------------------------------------------------------------------------
module tb_gmii_tx_arb;

  localparam int IPG           = 12;
  localparam int START_TIMEOUT = 16;

  // One directed transaction on the default instance, with the cumulative
  // counter values expected once it has completed.
  typedef struct packed {
    logic       src;
    logic [7:0] len;
    logic [7:0] base;
    logic       noise;
    logic       no_start;
    logic [1:0] exp_grant;
    logic [7:0] exp_pkt;
    logic [7:0] exp_abort;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gmii_tx_arb_if if_a ();
  gmii_tx_arb_if if_t ();

  logic [7:0] txd_a, txd_t;
  logic       en_a, er_a, en_t, er_t;
  logic       busy_a, busy_t;
  logic [7:0] pkt_a, abort_a, pkt_t, abort_t;

  int n_vec = 0;
  int n_miss = 0;

  vec_t vecs [6];

  // Free-running 125 MHz Tx clock.
  always #4 clk = ~clk;

  gmii_tx_arb #(
    .IPG(IPG),
    .START_TIMEOUT(START_TIMEOUT),
    .MAX_LEN_DW(14)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src(if_a),
    .gmii_txd(txd_a),
    .gmii_tx_en(en_a),
    .gmii_tx_er(er_a),
    .busy(busy_a),
    .pkt_count(pkt_a),
    .abort_count(abort_a)
  );

  gmii_tx_arb #(
    .IPG(IPG),
    .START_TIMEOUT(START_TIMEOUT),
    .MAX_LEN_DW(6)
  ) dut_t (
    .clk(clk),
    .rst_n(rst_n),
    .src(if_t),
    .gmii_txd(txd_t),
    .gmii_tx_en(en_t),
    .gmii_tx_er(er_t),
    .busy(busy_t),
    .pkt_count(pkt_t),
    .abort_count(abort_t)
  );

  // Monitor on the default instance: counts enabled cycles and 0xFF bytes,
  // logs the idle run preceding every frame and every new grant.
  int         en_cnt_a = 0;
  int         ff_cnt_a = 0;
  int         idle_run = 0;
  logic       prev_en = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  int         gaps [$];
  logic [1:0] grant_log [$];

  always @(negedge clk) begin
    prev_en    <= en_a;
    prev_grant <= if_a.grant;
    if (if_a.grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(if_a.grant);
    if (en_a) begin
      en_cnt_a <= en_cnt_a + 1;
      if (txd_a == 8'hFF) ff_cnt_a <= ff_cnt_a + 1;
      if (!prev_en) gaps.push_back(idle_run);
      idle_run <= 0;
    end else begin
      idle_run <= idle_run + 1;
    end
  end

  // Monitor on the truncation instance: its only frame carries bytes
  // 0,1,2,... so each output byte must equal its index within the frame.
  int         t_en_cnt = 0;
  int         t_er_cnt = 0;
  int         t_er_pos = 0;
  int         t_bad = 0;
  logic [7:0] t_er_byte = 8'h00;

  always @(negedge clk) begin
    if (en_t) begin
      t_en_cnt <= t_en_cnt + 1;
      if (txd_t != 8'(t_en_cnt)) t_bad <= t_bad + 1;
      if (er_t) begin
        t_er_cnt  <= t_er_cnt + 1;
        t_er_byte <= txd_t;
        t_er_pos  <= t_en_cnt + 1;
      end
    end
  end

  // Hard stop in case a sequence wedges despite its own bounds.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearSources();
    if_a.req    = 2'b00;
    if_a.src_d0 = 8'h00;
    if_a.src_d1 = 8'h00;
    if_a.src_en = 2'b00;
    if_a.src_er = 2'b00;
    if_t.req    = 2'b00;
    if_t.src_d0 = 8'h00;
    if_t.src_d1 = 8'h00;
    if_t.src_en = 2'b00;
    if_t.src_er = 2'b00;
  endtask

  task automatic waitIdle(input bit on_t, input string name);
    int n;
    n = 0;
    while ((on_t ? busy_t : busy_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput({name, " idle wait"}, 32'd1, 32'd0);
  endtask

  task automatic driveByte(input int s, input logic [7:0] b);
    if (s == 0) if_a.src_d0 = b;
    else        if_a.src_d1 = b;
    if_a.src_en[s] = 1'b1;
  endtask

  // Streams one frame from source s starting at the negedge where its grant
  // was seen. Each byte must appear on gmii_txd one cycle after it was
  // presented; the optional noise toggles the other source with 0xFF data.
  task automatic sendFrame(input int s, input int len, input logic [7:0] base,
                           input bit noise, output int bad, output bit end_ok);
    int o;
    o = 1 - s;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && !(en_a && !er_a && txd_a == base + 8'(i - 1))) bad++;
      driveByte(s, base + 8'(i));
      if (noise) begin
        if (o == 0) if_a.src_d0 = 8'hFF;
        else        if_a.src_d1 = 8'hFF;
        if_a.src_en[o] = i[0];
        if_a.src_er[o] = ~i[0];
      end
      @(negedge clk);
    end
    if (!(en_a && !er_a && txd_a == base + 8'(len - 1))) bad++;
    if_a.src_en = 2'b00;
    if_a.src_er = 2'b00;
    if_a.src_d0 = 8'h00;
    if_a.src_d1 = 8'h00;
    @(negedge clk);
    end_ok = (if_a.grant == 2'b00) && !en_a;
  endtask

  // Runs one table vector on the default instance and compares grant
  // latency, forwarded data, enable length and the counters.
  task automatic applyStimulus(input vec_t v, input int idx);
    string nm;
    int    en0, ff0, bad, gcyc, gapc;
    bit    end_ok;
    nm = $sformatf("vec%0d", idx);
    waitIdle(1'b0, nm);
    @(negedge clk);
    en0 = en_cnt_a;
    ff0 = ff_cnt_a;
    if_a.req[v.src] = 1'b1;
    @(negedge clk);
    checkOutput({nm, " grant"}, 32'(if_a.grant), 32'(v.exp_grant));
    if_a.req[v.src] = 1'b0;
    if (v.no_start) begin
      gcyc = 1;
      while (gcyc < 100) begin
        @(negedge clk);
        if (if_a.grant == 2'b00) break;
        gcyc++;
      end
      gapc = 0;
      while (busy_a && gapc < 100) begin
        gapc++;
        @(negedge clk);
      end
      checkOutput({nm, " grant cycles"}, 32'(gcyc), 32'(START_TIMEOUT));
      checkOutput({nm, " gap cycles"}, 32'(gapc), 32'(IPG));
      checkOutput({nm, " tx_en cycles"}, 32'(en_cnt_a - en0), 32'd0);
    end else begin
      sendFrame(int'(v.src), int'(v.len), v.base, v.noise, bad, end_ok);
      checkOutput({nm, " byte errors"}, 32'(bad), 32'd0);
      checkOutput({nm, " end of packet"}, 32'(end_ok), 32'd1);
      waitIdle(1'b0, nm);
      checkOutput({nm, " tx_en cycles"}, 32'(en_cnt_a - en0), 32'(v.len));
      if (v.noise) checkOutput({nm, " 0xFF bytes"}, 32'(ff_cnt_a - ff0), 32'd0);
    end
    checkOutput({nm, " pkt_count"}, 32'(pkt_a), 32'(v.exp_pkt));
    checkOutput({nm, " abort_count"}, 32'(abort_a), 32'(v.exp_abort));
  endtask

  // Both sources request together after reset and each sends two 60-byte
  // frames back to back. Between frames tx_en is low for IPG GAP cycles,
  // the IDLE arbitration cycle and the WAIT cycle that registers byte 0.
  task automatic runContention();
    int act [2];
    int bidx [2];
    int frames [2];
    int g0, l0, e0, cyc;
    logic [1:0] exp_order [4];
    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b01;
    exp_order[3] = 2'b10;
    for (int s = 0; s < 2; s++) begin
      act[s] = 0;
      bidx[s] = 0;
      frames[s] = 0;
    end
    @(negedge clk);
    g0 = gaps.size();
    l0 = grant_log.size();
    e0 = en_cnt_a;
    if_a.req = 2'b11;
    cyc = 0;
    while (cyc < 3000 && !(frames[0] == 2 && frames[1] == 2)) begin
      @(negedge clk);
      cyc++;
      for (int s = 0; s < 2; s++) begin
        if (act[s] != 0) begin
          if (bidx[s] < 60) begin
            driveByte(s, 8'(bidx[s] + 64 * s));
            bidx[s]++;
          end else begin
            if_a.src_en[s] = 1'b0;
            act[s] = 0;
            frames[s]++;
            if (frames[s] < 2) if_a.req[s] = 1'b1;
          end
        end else if (if_a.req[s] && if_a.grant[s]) begin
          if_a.req[s] = 1'b0;
          act[s] = 1;
          driveByte(s, 8'(64 * s));
          bidx[s] = 1;
        end
      end
    end
    if (cyc >= 3000) checkOutput("contention frames done", 32'd0, 32'd1);
    clearSources();
    waitIdle(1'b0, "contention");
    checkOutput("contention grant count", 32'(grant_log.size() - l0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (l0 + k < grant_log.size())
        checkOutput($sformatf("contention grant %0d", k), 32'(grant_log[l0 + k]), 32'(exp_order[k]));
    end
    for (int k = 1; k < 4; k++) begin
      if (g0 + k < gaps.size())
        checkOutput($sformatf("contention gap %0d", k), 32'(gaps[g0 + k]), 32'(IPG + 2));
      else
        checkOutput($sformatf("contention gap %0d present", k), 32'd0, 32'd1);
    end
    checkOutput("contention tx_en cycles", 32'(en_cnt_a - e0), 32'd240);
    checkOutput("contention pkt_count", 32'(pkt_a), 32'd4);
    checkOutput("contention abort_count", 32'(abort_a), 32'd0);
  endtask

  // Source 0 of the 6-bit instance holds en for 100 bytes: 63 leave the
  // block, the 63rd flagged bad, and the rest are swallowed in DRAIN.
  task automatic runTruncation();
    int n;
    @(negedge clk);
    if_t.req[0] = 1'b1;
    n = 0;
    while (!if_t.grant[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("trunc grant wait", 32'd0, 32'd1);
    if_t.req[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 70) begin
        checkOutput("trunc drain grant", 32'(if_t.grant), 32'd0);
        checkOutput("trunc drain tx_en", 32'(en_t), 32'd0);
        checkOutput("trunc drain busy", 32'(busy_t), 32'd1);
      end
      if_t.src_d0 = 8'(i);
      if_t.src_en[0] = 1'b1;
      @(negedge clk);
    end
    if_t.src_en = 2'b00;
    if_t.src_d0 = 8'h00;
    waitIdle(1'b1, "trunc");
    checkOutput("trunc tx_en cycles", 32'(t_en_cnt), 32'd63);
    checkOutput("trunc byte errors", 32'(t_bad), 32'd0);
    checkOutput("trunc tx_er cycles", 32'(t_er_cnt), 32'd1);
    checkOutput("trunc tx_er position", 32'(t_er_pos), 32'd63);
    checkOutput("trunc tx_er byte", 32'(t_er_byte), 32'h3E);
    checkOutput("trunc abort_count", 32'(abort_t), 32'd1);
    checkOutput("trunc pkt_count", 32'(pkt_t), 32'd0);
  endtask

  // Main sequence: reset values, the vector table, a mid-frame async reset,
  // contention and truncation, then the summary line.
  initial begin
    vec_t fresh;
    clearSources();
    vecs[0] = '{src: 1'b0, len: 8'd64, base: 8'h00, noise: 1'b0, no_start: 1'b0,
                exp_grant: 2'b01, exp_pkt: 8'd1, exp_abort: 8'd0};
    vecs[1] = '{src: 1'b1, len: 8'd20, base: 8'h80, noise: 1'b1, no_start: 1'b0,
                exp_grant: 2'b10, exp_pkt: 8'd2, exp_abort: 8'd0};
    vecs[2] = '{src: 1'b0, len: 8'd30, base: 8'h40, noise: 1'b1, no_start: 1'b0,
                exp_grant: 2'b01, exp_pkt: 8'd3, exp_abort: 8'd0};
    vecs[3] = '{src: 1'b1, len: 8'd0,  base: 8'h00, noise: 1'b0, no_start: 1'b1,
                exp_grant: 2'b10, exp_pkt: 8'd3, exp_abort: 8'd1};
    vecs[4] = '{src: 1'b0, len: 8'd1,  base: 8'hA5, noise: 1'b0, no_start: 1'b0,
                exp_grant: 2'b01, exp_pkt: 8'd4, exp_abort: 8'd1};
    vecs[5] = '{src: 1'b1, len: 8'd2,  base: 8'hFE, noise: 1'b0, no_start: 1'b0,
                exp_grant: 2'b10, exp_pkt: 8'd5, exp_abort: 8'd1};
    fresh   = '{src: 1'b1, len: 8'd10, base: 8'h10, noise: 1'b0, no_start: 1'b0,
                exp_grant: 2'b10, exp_pkt: 8'd1, exp_abort: 8'd0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset grant", 32'(if_a.grant), 32'd0);
    checkOutput("reset gmii_txd", 32'(txd_a), 32'd0);
    checkOutput("reset gmii_tx_en", 32'(en_a), 32'd0);
    checkOutput("reset gmii_tx_er", 32'(er_a), 32'd0);
    checkOutput("reset busy", 32'(busy_a), 32'd0);
    checkOutput("reset pkt_count", 32'(pkt_a), 32'd0);
    checkOutput("reset abort_count", 32'(abort_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    $display("[TB] async reset in mid-frame");
    waitIdle(1'b0, "areset");
    @(negedge clk);
    if_a.req[0] = 1'b1;
    @(negedge clk);
    if_a.req[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      driveByte(0, 8'h20 + 8'(i));
      @(negedge clk);
    end
    checkOutput("areset frame active", 32'(en_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset gmii_tx_en", 32'(en_a), 32'd0);
    checkOutput("areset gmii_txd", 32'(txd_a), 32'd0);
    checkOutput("areset grant", 32'(if_a.grant), 32'd0);
    checkOutput("areset busy", 32'(busy_a), 32'd0);
    checkOutput("areset pkt_count", 32'(pkt_a), 32'd0);
    checkOutput("areset abort_count", 32'(abort_a), 32'd0);
    clearSources();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(fresh, 6);

    $display("[TB] contention after reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runContention();

    $display("[TB] truncation on 6-bit length counter");
    runTruncation();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
